// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The master drives operands and result back-pressure; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, V, Z
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, V, Z
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: D = A - B - Bin, one SLICE-bit slice
// per clock, LSB slice first. Operands are shifted right as slices are consumed
// and the result is shifted in from the top, so no variable part-selects are needed.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
  logic             a_msb, b_msb, borrow;
  logic [CW-1:0]    cnt;
  logic [SLICE:0]   diff;
  logic             last, accept, retire;

  // Current slice difference at SLICE+1 bits; top bit is the borrow out.
  assign diff    = {1'b0, a_r[SLICE-1:0]} - {1'b0, b_r[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
  // New slice enters at the top; after N cycles slice 0 has reached the bottom.
  assign res_nxt = WIDTH'({diff[SLICE-1:0], res} >> SLICE);
  assign last    = (cnt == CW'(N - 1));

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE) & ~rst;
  assign accept        = bus.in_valid & bus.in_ready;
  assign retire        = bus.out_valid & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept -> N slice cycles -> hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    if (retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice borrow ripple, and result/flag load on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      res      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow   <= 1'b0;
      cnt      <= '0;
      bus.D    <= '0;
      bus.Bout <= 1'b0;
      bus.V    <= 1'b0;
      bus.Z    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r    <= bus.A;
          b_r    <= bus.B;
          a_msb  <= bus.A[WIDTH-1];
          b_msb  <= bus.B[WIDTH-1];
          borrow <= bus.Bin;
          cnt    <= '0;
        end
        RUN: begin
          a_r    <= a_r >> SLICE;
          b_r    <= b_r >> SLICE;
          res    <= res_nxt;
          borrow <= diff[SLICE];
          if (!last) cnt <= cnt + CW'(1);
          if (last) begin
            bus.D    <= res_nxt;
            bus.Bout <= diff[SLICE];
            // Sign overflow uses the original operand signs only; Bin is not part of it.
            bus.V    <= (a_msb != b_msb) & (res_nxt[WIDTH-1] != a_msb);
            bus.Z    <= ~|res_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 8-bit-slice and single-slice instances
// compared against a plain-arithmetic reference of A - B - Bin.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(32)) s8 ();
  serial_subtractor_if #(.WIDTH(32)) s32 ();

  serial_subtractor #(.WIDTH(32), .SLICE(8))  dut8  (.clk(clk), .rst(rst), .bus(s8));
  serial_subtractor #(.WIDTH(32), .SLICE(32)) dut32 (.clk(clk), .rst(rst), .bus(s32));

  int tests = 0;
  int fails = 0;

  // Reference: {Bout, V, Z, D} from full-width arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] t;
    logic [31:0] d;
    logic        v;
    t = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    d = t[31:0];
    v = (a[31] != b[31]) && (d[31] != a[31]);
    return {t[32], v, (d == 32'd0), d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the 8-bit-slice instance with out_ready held high.
  task automatic op8(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [34:0] e;
    int n;
    e = model(a, b, bin);
    @(negedge clk);
    s8.in_valid = 1'b1; s8.A = a; s8.B = b; s8.Bin = bin; s8.out_ready = 1'b1;
    n = 0;
    while (!s8.in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 64'(s8.in_ready), 64'd1);
    @(negedge clk);
    s8.in_valid = 1'b0;
    n = 0;
    while (!s8.out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_D"}, 64'(s8.D), 64'(e[31:0]));
    chk({tag, "_flags"}, 64'({s8.Bout, s8.V, s8.Z}), 64'(e[34:32]));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({s8.out_valid, s8.in_ready}), 64'b01);
  endtask

  initial begin
    logic [34:0] e1, e2;
    logic [31:0] ra, rb;
    int n;
    logic seen;

    rst = 1'b1;
    s8.in_valid = 1'b0;  s8.A = '0;  s8.B = '0;  s8.Bin = 1'b0;  s8.out_ready = 1'b0;
    s32.in_valid = 1'b0; s32.A = '0; s32.B = '0; s32.Bin = 1'b0; s32.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_hs", 64'({s8.in_ready, s8.out_valid}), 64'd0);
    chk("rst_out", 64'({s8.D, s8.Bout, s8.V, s8.Z}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(s8.in_ready), 64'd1);

    // Directed cases.
    op8("t1",  32'h00000005, 32'h00000003, 1'b0);
    op8("t2",  32'h00000000, 32'h00000001, 1'b0);
    op8("t3a", 32'h80000000, 32'h00000001, 1'b0);
    op8("t3b", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    op8("t4",  32'h12345678, 32'h12345677, 1'b1);
    op8("bmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    // Random operands, with some equal pairs to reach the zero flag.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      op8($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Backpressure: result held while new operands are offered.
    e1 = model(32'hDEADBEEF, 32'h0BADF00D, 1'b0);
    e2 = model(32'h00001000, 32'h00002000, 1'b1);
    @(negedge clk);
    s8.out_ready = 1'b0; s8.in_valid = 1'b1;
    s8.A = 32'hDEADBEEF; s8.B = 32'h0BADF00D; s8.Bin = 1'b0;
    @(negedge clk);
    s8.A = 32'h00001000; s8.B = 32'h00002000; s8.Bin = 1'b1;
    n = 0;
    while (!s8.out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i),
          64'({s8.out_valid, s8.in_ready, s8.Bout, s8.V, s8.Z, s8.D}),
          64'({1'b1, 1'b0, e1[34:32], e1[31:0]}));
      @(negedge clk);
    end
    s8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({s8.out_valid, s8.in_ready}), 64'b01);
    @(negedge clk);
    s8.in_valid = 1'b0;
    n = 0;
    while (!s8.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_second_lat", 64'(n), 64'd4);
    chk("bp_second_res", 64'({s8.Bout, s8.V, s8.Z, s8.D}), 64'(e2));
    @(negedge clk);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    s8.in_valid = 1'b1; s8.A = 32'h00000005; s8.B = 32'h00000003; s8.Bin = 1'b0;
    @(negedge clk);
    s8.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_during", 64'({s8.out_valid, s8.in_ready, s8.Bout, s8.V, s8.Z, s8.D}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(s8.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s8.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    chk("midrst_cleared", 64'({s8.Bout, s8.V, s8.Z, s8.D}), 64'd0);

    // Single-slice instance: one RUN cycle.
    s32.in_valid = 1'b1; s32.A = 32'h00000005; s32.B = 32'h00000003; s32.Bin = 1'b0;
    s32.out_ready = 1'b1;
    chk("w32_ready", 64'(s32.in_ready), 64'd1);
    @(negedge clk);
    s32.in_valid = 1'b0;
    n = 0;
    while (!s32.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("w32_lat", 64'(n), 64'd1);
    chk("w32_res", 64'({s32.Bout, s32.V, s32.Z, s32.D}), 64'(model(32'h5, 32'h3, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle ripple-borrow subtractor for the datapath: computes D = A - B - Bin.
- Works on one SLICE-bit slice per clock, LSB slice first, and carries the borrow between cycles.
- Complements the gate-level adder chain: serves the effective-subtraction path (mantissa alignment and difference) where area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
WIDTH, 32, operand and result width in bits.
SLICE, 8, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/SLICE cycles per operation.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands A, B and Bin are valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  minuend.
B  input  WIDTH  subtrahend.
Bin  input  1  borrow-in.
out_valid  output  1  result outputs are valid.
out_ready  input  1  consumer accepts the result.
D  output  WIDTH  difference, modulo 2^WIDTH.
Bout  output  1  final borrow-out; 1 if and only if unsigned A < B + Bin.
V  output  1  two's-complement overflow.
Z  output  1  1 when D == 0.

Behaviour:
- Reset, while rst is high:
  - state returns to IDLE;
  - out_valid=0, D=0, Bout=0, V=0, Z=0, internal borrow and slice counter cleared;
  - in_ready=0.
  - in_ready=1 on the first cycle after rst falls.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch A, B and Bin; set borrow=Bin and counter=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, for slice k = counter: {b_next, d_k} = A[k] - B[k] - borrow, computed at SLICE+1 bits.
  - Store d_k into the internal result register, set borrow = b_next, counter++.
  - When counter == N-1, the last slice is processed that cycle and the state goes to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - D, Bout, V and Z are loaded on entry to DONE and held stable until out_ready is high.
  - On out_valid & out_ready, go to IDLE; out_valid=0 and in_ready=1 on the next cycle.
- Latency: operands accepted at edge t produce out_valid=1 after edge t+N. The minimum accept-to-accept interval is N+1 cycles. Operations never overlap.
- Flags:
  - Bout = borrow out of the top slice.
  - V = (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]). Bin is not included in the sign test.
  - Z = ~|D.
- Outputs D and flags change only on entry to DONE or on reset. Between operations they keep the last result while out_valid=0.
- SLICE == WIDTH is legal: N=1, single RUN cycle.
- The counter width is max(1, clog2(N)). The counter does not wrap during RUN because the state exits at N-1.
- Reset mid-operation (RUN or DONE): the operation is aborted, no out_valid pulse, outputs cleared, in_ready=1 the cycle after reset releases.
- out_ready held high before DONE has no effect. in_valid held high during RUN/DONE does not queue a second operation; the operands are accepted only once the block is back in IDLE.
- X on A/B while not being accepted has no effect.

Test Plan:
1. WIDTH=32, SLICE=8: A=0x00000005, B=0x00000003, Bin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; D=0x00000002, Bout=0, V=0, Z=0.
2. A=0x00000000, B=0x00000001, Bin=0 -> D=0xFFFFFFFF, Bout=1, V=0, Z=0 (borrow ripples through all 4 slices).
3. A=0x80000000, B=0x00000001, Bin=0 -> D=0x7FFFFFFF, Bout=0, V=1. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, Bout=1, V=1.
4. A=0x12345678, B=0x12345677, Bin=1 -> D=0x00000000, Z=1, Bout=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, D and flags stay stable, in_ready=0, new operands not taken. Raise out_ready -> handshake; in_ready=1 the next cycle; new operation accepted and completes correctly.
6. Assert rst for one cycle at the 2nd RUN cycle -> out_valid never pulses, D=0 and flags 0, in_ready=1 the cycle after release. Also rerun scenario 1 with SLICE=32 -> out_valid 1 cycle after accept, same D.
